lsu_mmio_gen: RTL and testbench
===============================

Name: lsu_mmio_gen

Overview:
- Parametrised load/store unit for the single-cycle/pipelined RV32I core.
- Decodes the data-side memory map into three regions: data memory (DM), output peripheral registers, and synchronised switch input.
- Supports byte, halfword and word loads and stores with sign or zero extension.
- Uses a request/valid handshake with a one-cycle synchronous DM read, and flags misaligned accesses.

Parameters:
- DM_DEPTH, 2048, number of 32-bit DM words (power of 2, at most 2048); DM window is 0x2000–0x3FFF, word index addr_i[12:2] modulo DM_DEPTH.
- NUM_HEX, 8, number of 7-segment digits driven (1–8).
- SW_SYNC_STAGES, 2, flop stages on io_sw_i (at least 2).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- req_i  in  1  access request; accepted when req_i && !busy_o
- we_i  in  1  1 = store, 0 = load (sampled on accept)
- mem_op_i  in  3  funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; other codes treated as 010
- addr_i  in  32  byte address
- st_data_i  in  32  store data, right-aligned
- io_sw_i  in  32  asynchronous switch inputs
- ld_data_o  out  32  extended load result, valid while ld_valid_o
- ld_valid_o  out  1  one-cycle pulse, load result ready
- busy_o  out  1  unit cannot accept a request this cycle
- misalign_o  out  1  one-cycle pulse, previous accepted access was misaligned
- io_ledr_o  out  32  red LEDs
- io_ledg_o  out  32  green LEDs
- io_hex_o  out  7*NUM_HEX  digit k at bits [7k+6:7k]
- io_lcd_o  out  32  LCD register

Behaviour:
- Clock and reset: single clock clk_i; reset is synchronous and active-high on rst_i.
- Reset values: ld_data_o=0, ld_valid_o=0, busy_o=0, misalign_o=0; all peripheral registers 0, so all io outputs are 0; synchroniser flops 0; FSM in IDLE.
  - DM contents are not reset (block-RAM inference).
- Address map (addr_i[15:0]; bits [31:16] ignored):
  - 0x2000–0x3FFF DM.
  - 0x7000 LEDR; 0x7010 LEDG; 0x7020 HEX0–3; 0x7024 HEX4–7; 0x7030 LCD.
  - 0x7800 switches (read-only).
  - Everything else is unmapped: loads return 0, stores are dropped.
- Hex digit mapping: digit n takes byte (n mod 4), bits [6:0], of its HEX register. Digits at or above NUM_HEX are not driven.
- Byte lanes: SB writes lane addr_i[1:0], SH writes lanes {addr_i[1],0} and {addr_i[1],1}, SW writes all 4 lanes.
  - The same lane enables apply to DM and to the peripheral registers.
  - Store data is replicated into the addressed lanes.
- Load extraction: the selected byte/halfword is shifted to bit 0. LB/LH sign-extend; LBU/LHU zero-extend.
- Misalignment: LH/LHU/SH with addr_i[0]=1, or LW/SW with addr_i[1:0]≠0.
  - Misaligned stores write nothing.
  - Misaligned loads return ld_data_o=0.
- FSM states: IDLE, LOAD.
  - IDLE, accepted store: write at that clock edge; stay in IDLE. busy_o stays 0, so back-to-back stores run at 1 per cycle.
  - IDLE, accepted load: register address/op, go to LOAD. busy_o=1 in LOAD.
  - LOAD: ld_valid_o=1 and ld_data_o=extended data; return to IDLE. Load latency is exactly 1 cycle after accept; next accept no earlier than the cycle after ld_valid_o.
- misalign_o pulses in the cycle after acceptance; for a misaligned load it coincides with ld_valid_o.
- ld_data_o holds its last value when ld_valid_o=0.
- A read of a location stored in the previous cycle returns the new data (DM write-first or bypass).
- Switches: io_sw_i passes through SW_SYNC_STAGES flops. A load of 0x7800 returns the last stage; 0x7804–0x780F return 0. Stores to the switch range are dropped.
- rst_i asserted while in LOAD: the FSM goes to IDLE, no ld_valid_o pulse, busy_o=0 in the next cycle.
- req_i asserted during busy_o is ignored and not queued; the requester must hold it.

Test Plan:
- Reset, then SW 0x2000=0xDEADBEEF → next cycle LW 0x2000 → one cycle after accept: ld_valid_o=1, ld_data_o=0xDEADBEEF, busy_o=1 for that one cycle.
- After SW 0x2004=0x000080F0: LB 0x2004→0xFFFFFFF0, LBU 0x2004→0x000000F0, LH 0x2004→0xFFFF80F0, LHU 0x2006→0x00000000.
- SB 0x7020=0x3F then SB 0x7021=0x06, then SW 0x7024=0x7F6D4F5B → io_hex_o digit0=0x3F, digit1=0x06, digits 4–7=0x5B,0x4F,0x6D,0x7F; SW 0x7000=0xA5 → io_ledr_o=0x000000A5.
- SW 0x2002=0x12345678 → misalign_o pulse, word at 0x2000 unchanged; LH 0x2001 → ld_valid_o=1, misalign_o=1, ld_data_o=0.
- io_sw_i=0x00000155 held → LW 0x7800 issued 1 cycle later returns pre-sync value 0, issued at least SW_SYNC_STAGES cycles later returns 0x155; SW 0x7800=0xFFFFFFFF → switch read unchanged.
- Accept LW, assert rst_i in the LOAD cycle → no ld_valid_o, all io outputs 0, busy_o=0 the following cycle; LW 0x5000 (unmapped) → ld_data_o=0.

Source files
------------

// File: rtl/lsu_mmio_gen.sv
// lsu_mmio_gen: RV32I load/store unit. It decodes data memory (DM), output
// registers and synchronised switches, and supports B/H/W loads and stores.
// Ports:
//   clk_i, rst_i (sync, active-high)
//   req_i/we_i/mem_op_i/addr_i/st_data_i: request side
//   ld_data_o/ld_valid_o/busy_o/misalign_o: response side
//   io_sw_i in; io_ledr_o, io_ledg_o, io_hex_o, io_lcd_o out
module lsu_mmio_gen #(
  parameter int DM_DEPTH       = 2048,
  parameter int NUM_HEX        = 8,
  parameter int SW_SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [2:0]           mem_op_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          st_data_i,
  input  logic [31:0]          io_sw_i,
  output logic [31:0]          ld_data_o,
  output logic                 ld_valid_o,
  output logic                 busy_o,
  output logic                 misalign_o,
  output logic [31:0]          io_ledr_o,
  output logic [31:0]          io_ledg_o,
  output logic [7*NUM_HEX-1:0] io_hex_o,
  output logic [31:0]          io_lcd_o
);
  localparam int AW = $clog2(DM_DEPTH);

  typedef enum logic {IDLE, LOAD} state_e;
  state_e state_q, state_d;

  logic [31:0]   dm [DM_DEPTH];
  logic [AW-1:0] dm_idx;
  logic [13:0]   wa;
  logic          is_b, is_h, is_w, is_u, mis;
  logic [3:0]    be;
  logic [31:0]   wdata, io_rd;
  logic          hit_dm, hit_ledr, hit_ledg;
  logic          hit_hlo, hit_hhi, hit_lcd, hit_sw;
  logic          acc, st_ok, ld_acc;

  logic [31:0] ledr_q, ledg_q, hlo_q, hhi_q, lcd_q;
  logic [SW_SYNC_STAGES-1:0][31:0] sw_q;

  logic [31:0] dm_rd_q, io_rd_q, hold_q;
  logic        ld_dm_q, ld_mis_q, mis_q;
  logic        ld_b_q, ld_h_q, ld_u_q;
  logic [1:0]  ld_off_q;
  logic [31:0] raw, sh, ld_ext;

  logic unused_addr;
  assign unused_addr = ^{addr_i[31:16], addr_i[12:2]};

  function automatic logic [31:0] merge(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  en
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = en[i] ? new_w[8*i +: 8]
                          : old_w[8*i +: 8];
    return r;
  endfunction

  always_comb begin
    is_b = 1'b0;
    is_h = 1'b0;
    is_u = 1'b0;
    unique case (mem_op_i)
      3'b000: is_b = 1'b1;
      3'b001: is_h = 1'b1;
      3'b100: begin
        is_b = 1'b1;
        is_u = 1'b1;
      end
      3'b101: begin
        is_h = 1'b1;
        is_u = 1'b1;
      end
      default: ;
    endcase
  end

  assign is_w = !is_b && !is_h;
  assign mis  = (is_h && addr_i[0]) ||
                (is_w && (addr_i[1:0] != 2'b00));

  always_comb begin
    be = 4'b0000;
    unique case (1'b1)
      is_b:    be[addr_i[1:0]] = 1'b1;
      is_h:    be = addr_i[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Store data is replicated so every enabled lane sees its bytes.
  assign wdata = is_b ? {4{st_data_i[7:0]}}  :
                 is_h ? {2{st_data_i[15:0]}} :
                        st_data_i;

  assign wa       = addr_i[15:2];
  assign dm_idx   = addr_i[2 +: AW];
  assign hit_dm   = addr_i[15:13] == 3'b001;
  assign hit_ledr = wa == 14'h1C00;
  assign hit_ledg = wa == 14'h1C04;
  assign hit_hlo  = wa == 14'h1C08;
  assign hit_hhi  = wa == 14'h1C09;
  assign hit_lcd  = wa == 14'h1C0C;
  assign hit_sw   = wa == 14'h1E00;

  assign busy_o = state_q == LOAD;
  assign acc    = req_i && !busy_o;
  assign st_ok  = acc && we_i && !mis;
  assign ld_acc = acc && !we_i;

  always_comb begin
    io_rd = '0;
    unique case (1'b1)
      hit_ledr: io_rd = ledr_q;
      hit_ledg: io_rd = ledg_q;
      hit_hlo:  io_rd = hlo_q;
      hit_hhi:  io_rd = hhi_q;
      hit_lcd:  io_rd = lcd_q;
      hit_sw:   io_rd = sw_q[SW_SYNC_STAGES-1];
      default:  ;
    endcase
  end

  // DM is not reset so it maps onto block RAM with byte enables.
  always_ff @(posedge clk_i) begin
    if (st_ok && hit_dm)
      for (int i = 0; i < 4; i++)
        if (be[i])
          dm[dm_idx][8*i +: 8] <= wdata[8*i +: 8];
    if (ld_acc)
      dm_rd_q <= dm[dm_idx];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (ld_acc) state_d = LOAD;
      LOAD: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ledr_q   <= '0;
      ledg_q   <= '0;
      hlo_q    <= '0;
      hhi_q    <= '0;
      lcd_q    <= '0;
      sw_q     <= '0;
      io_rd_q  <= '0;
      hold_q   <= '0;
      ld_dm_q  <= 1'b0;
      ld_mis_q <= 1'b0;
      ld_b_q   <= 1'b0;
      ld_h_q   <= 1'b0;
      ld_u_q   <= 1'b0;
      ld_off_q <= '0;
      mis_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sw_q    <= {sw_q[SW_SYNC_STAGES-2:0], io_sw_i};
      mis_q   <= acc && mis;
      if (st_ok) begin
        if (hit_ledr) ledr_q <= merge(ledr_q, wdata, be);
        if (hit_ledg) ledg_q <= merge(ledg_q, wdata, be);
        if (hit_hlo)  hlo_q  <= merge(hlo_q, wdata, be);
        if (hit_hhi)  hhi_q  <= merge(hhi_q, wdata, be);
        if (hit_lcd)  lcd_q  <= merge(lcd_q, wdata, be);
      end
      // Everything a load needs is captured at accept, so the
      // switch value is the one visible in the request cycle.
      if (ld_acc) begin
        ld_dm_q  <= hit_dm;
        io_rd_q  <= io_rd;
        ld_mis_q <= mis;
        ld_b_q   <= is_b;
        ld_h_q   <= is_h;
        ld_u_q   <= is_u;
        ld_off_q <= addr_i[1:0];
      end
      if (ld_valid_o)
        hold_q <= ld_ext;
    end
  end

  always_comb begin
    raw = ld_dm_q ? dm_rd_q : io_rd_q;
    sh  = raw >> {ld_off_q, 3'b000};
    if (ld_mis_q)
      ld_ext = '0;
    else if (ld_b_q)
      ld_ext = {{24{sh[7] & !ld_u_q}}, sh[7:0]};
    else if (ld_h_q)
      ld_ext = {{16{sh[15] & !ld_u_q}}, sh[15:0]};
    else
      ld_ext = sh;
  end

  // A reset arriving in LOAD suppresses the pending response.
  assign ld_valid_o = busy_o && !rst_i;
  assign ld_data_o  = ld_valid_o ? ld_ext : hold_q;
  assign misalign_o = mis_q;

  assign io_ledr_o = ledr_q;
  assign io_ledg_o = ledg_q;
  assign io_lcd_o  = lcd_q;

  for (genvar k = 0; k < NUM_HEX; k++) begin : g_hex
    if (k < 4) begin : g_lo
      assign io_hex_o[7*k +: 7] = hlo_q[8*k +: 7];
    end else begin : g_hi
      assign io_hex_o[7*k +: 7] = hhi_q[8*(k-4) +: 7];
    end
  end

endmodule

// File: tb/tb_lsu_mmio_gen.sv
// tb_lsu_mmio_gen: directed and random bench for lsu_mmio_gen.
// Byte-addressed reference model; checks via immediate assertions.
module tb_lsu_mmio_gen;
  localparam int DM_DEPTH = 2048;
  localparam int NUM_HEX  = 8;
  localparam int SW_SYNC  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we  = 1'b0;
  logic [2:0]  op  = '0;
  logic [31:0] addr = '0;
  logic [31:0] st   = '0;
  logic [31:0] sw   = '0;

  logic [31:0]          ld_data;
  logic                 ld_valid, busy, mis;
  logic [31:0]          ledr, ledg, lcd;
  logic [7*NUM_HEX-1:0] hex;

  lsu_mmio_gen #(
    .DM_DEPTH(DM_DEPTH),
    .NUM_HEX(NUM_HEX),
    .SW_SYNC_STAGES(SW_SYNC)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_i(req),
    .we_i(we),
    .mem_op_i(op),
    .addr_i(addr),
    .st_data_i(st),
    .io_sw_i(sw),
    .ld_data_o(ld_data),
    .ld_valid_o(ld_valid),
    .busy_o(busy),
    .misalign_o(mis),
    .io_ledr_o(ledr),
    .io_ledg_o(ledg),
    .io_hex_o(hex),
    .io_lcd_o(lcd)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  dmb [int];
  logic [31:0] per [int];
  logic [31:0] sw_vis = '0;
  logic [31:0] last_ld = '0;

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sz(input logic [2:0] o);
    case (o)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit model_mis(
    input logic [31:0] a,
    input logic [2:0]  o
  );
    return (int'(a[1:0]) % sz(o)) != 0;
  endfunction

  function automatic int dm_key(input int a16);
    return (((a16 - 'h2000) / 4) % DM_DEPTH) * 4 + a16 % 4;
  endfunction

  task automatic write_byte(input int a16, input logic [7:0] v);
    int w;
    int s;
    w = a16 & 'hFFFC;
    s = 8 * (a16 % 4);
    if (a16 >= 'h2000 && a16 < 'h4000)
      dmb[dm_key(a16)] = v;
    else if (per.exists(w))
      per[w] = (per[w] & ~(32'hFF << s)) | (32'(v) << s);
  endtask

  function automatic logic [7:0] read_byte(input int a16);
    int w;
    int s;
    w = a16 & 'hFFFC;
    s = 8 * (a16 % 4);
    if (a16 >= 'h2000 && a16 < 'h4000) return dmb[dm_key(a16)];
    if (per.exists(w)) return 8'(per[w] >> s);
    if (w == 'h7800) return 8'(sw_vis >> s);
    return 8'h00;
  endfunction

  task automatic model_store(
    input logic [31:0] a,
    input logic [2:0]  o,
    input logic [31:0] d
  );
    if (model_mis(a, o)) return;
    for (int k = 0; k < sz(o); k++)
      write_byte(int'(a[15:0]) + k, 8'(d >> (8 * k)));
  endtask

  function automatic logic [31:0] model_load(
    input logic [31:0] a,
    input logic [2:0]  o
  );
    logic [31:0] v;
    int n;
    n = sz(o);
    if (model_mis(a, o)) return '0;
    v = '0;
    for (int k = 0; k < n; k++)
      v = v | (32'(read_byte(int'(a[15:0]) + k)) << (8 * k));
    if (n == 1 && o == 3'b000 && v[7]) v = v | 32'hFFFF_FF00;
    if (n == 2 && o == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic reset_model();
    per['h7000] = '0;
    per['h7010] = '0;
    per['h7020] = '0;
    per['h7024] = '0;
    per['h7030] = '0;
    sw_vis  = '0;
    last_ld = '0;
  endtask

  task automatic check_io(input string tag);
    logic [63:0] hx;
    logic [31:0] w;
    hx = '0;
    for (int k = 0; k < NUM_HEX; k++) begin
      w = (k < 4) ? per['h7020] : per['h7024];
      hx[7*k +: 7] = 7'(w >> (8 * (k % 4)));
    end
    check({tag, " ledr"}, 64'(ledr), 64'(per['h7000]));
    check({tag, " ledg"}, 64'(ledg), 64'(per['h7010]));
    check({tag, " lcd"}, 64'(lcd), 64'(per['h7030]));
    check({tag, " hex"}, 64'(hex), hx);
  endtask

  task automatic store(
    input logic [31:0] a,
    input logic [2:0]  o,
    input logic [31:0] d,
    input string       tag
  );
    check({tag, " busy_pre"}, 64'(busy), 64'(0));
    req  = 1'b1;
    we   = 1'b1;
    op   = o;
    addr = a;
    st   = d;
    tick();
    req = 1'b0;
    check({tag, " mis"}, 64'(mis), 64'(model_mis(a, o)));
    model_store(a, o, d);
  endtask

  task automatic load(
    input  logic [31:0] a,
    input  logic [2:0]  o,
    input  string       tag,
    output logic [31:0] got
  );
    logic [31:0] e;
    e = model_load(a, o);
    check({tag, " busy_pre"}, 64'(busy), 64'(0));
    req  = 1'b1;
    we   = 1'b0;
    op   = o;
    addr = a;
    tick();
    req = 1'b0;
    check({tag, " valid"}, 64'(ld_valid), 64'(1));
    check({tag, " busy"}, 64'(busy), 64'(1));
    check({tag, " mis"}, 64'(mis), 64'(model_mis(a, o)));
    check({tag, " data"}, 64'(ld_data), 64'(e));
    got = ld_data;
    last_ld = e;
    tick();
    check({tag, " hold"}, {30'd0, ld_valid, busy, ld_data},
          {32'd0, e});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    logic [63:0] hx_exp;
    logic [31:0] a;
    logic [15:0] base;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    reset_model();
    check("rst ld_data", 64'(ld_data), 64'(0));
    check("rst valid", 64'(ld_valid), 64'(0));
    check("rst busy", 64'(busy), 64'(0));
    check("rst mis", 64'(mis), 64'(0));
    check_io("rst");

    store(32'h2000, 3'b010, 32'hDEADBEEF, "sw2000");
    load(32'h2000, 3'b010, "lw2000", got);
    check("lw2000 const", 64'(got), 64'(32'hDEADBEEF));

    store(32'h2004, 3'b010, 32'h0000_80F0, "sw2004");
    load(32'h2004, 3'b000, "lb2004", got);
    check("lb const", 64'(got), 64'(32'hFFFF_FFF0));
    load(32'h2004, 3'b100, "lbu2004", got);
    check("lbu const", 64'(got), 64'(32'h0000_00F0));
    load(32'h2004, 3'b001, "lh2004", got);
    check("lh const", 64'(got), 64'(32'hFFFF_80F0));
    load(32'h2006, 3'b101, "lhu2006", got);
    check("lhu const", 64'(got), 64'(32'h0));

    store(32'h7020, 3'b000, 32'h3F, "sb7020");
    store(32'h7021, 3'b000, 32'h06, "sb7021");
    store(32'h7024, 3'b010, 32'h7F6D4F5B, "sw7024");
    store(32'h7000, 3'b010, 32'hA5, "sw7000");
    hx_exp = {8'd0, 7'h7F, 7'h6D, 7'h4F, 7'h5B,
              7'h00, 7'h00, 7'h06, 7'h3F};
    check("hex const", 64'(hex), hx_exp);
    check("ledr const", 64'(ledr), 64'(32'hA5));
    check_io("periph");

    store(32'h2002, 3'b010, 32'h12345678, "sw_mis");
    check("sw_mis flag", 64'(mis), 64'(1));
    load(32'h2000, 3'b010, "lw_after_mis", got);
    check("mis no write", 64'(got), 64'(32'hDEADBEEF));
    load(32'h2001, 3'b001, "lh_mis", got);
    check("lh_mis zero", 64'(got), 64'(0));

    sw = 32'h155;
    tick();
    load(32'h7800, 3'b010, "sw_early", got);
    check("sw_early const", 64'(got), 64'(0));
    sw_vis = 32'h155;
    load(32'h7800, 3'b010, "sw_late", got);
    check("sw_late const", 64'(got), 64'(32'h155));
    store(32'h7800, 3'b010, 32'hFFFF_FFFF, "sw_ro");
    load(32'h7800, 3'b010, "sw_ro_rd", got);
    check("sw_ro const", 64'(got), 64'(32'h155));
    load(32'h7804, 3'b010, "sw_hole", got);

    check("pre_rst busy", 64'(busy), 64'(0));
    req  = 1'b1;
    we   = 1'b0;
    op   = 3'b010;
    addr = 32'h2000;
    tick();
    req = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_load valid", 64'(ld_valid), 64'(0));
    tick();
    rst = 1'b0;
    reset_model();
    check("rst_load busy", 64'(busy), 64'(0));
    check("rst_load valid2", 64'(ld_valid), 64'(0));
    check("rst_load data", 64'(ld_data), 64'(0));
    check_io("rst_load");
    load(32'h5000, 3'b010, "unmapped", got);
    check("unmapped const", 64'(got), 64'(0));

    for (int i = 0; i < 16; i++)
      store({16'($urandom), 16'h2000 + 16'(4 * i)}, 3'b010,
            $urandom, "init");
    store(32'h3FFC, 3'b010, $urandom, "init_top");

    sw = $urandom;
    for (int i = 0; i < SW_SYNC + 2; i++) tick();
    sw_vis = sw;

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: base = 16'h2000 + 16'(4 * $urandom_range(0, 15));
        4: begin
          case ($urandom_range(0, 4))
            0: base = 16'h7000;
            1: base = 16'h7010;
            2: base = 16'h7020;
            3: base = 16'h7024;
            default: base = 16'h7030;
          endcase
        end
        5: base = 16'h7800;
        6: base = 16'h7804 + 16'(4 * $urandom_range(0, 2));
        7: base = 16'($urandom_range(0, 'h1FFF));
        8: base = 16'h3FFC;
        default: base = 16'h2000;
      endcase
      a = {16'($urandom), base[15:2], 2'($urandom)};
      if ($urandom_range(0, 1) == 1)
        store(a, 3'($urandom), $urandom, "rnd_st");
      else
        load(a, 3'($urandom), "rnd_ld", got);
      if (i % 25 == 24) check_io("rnd");
    end
    check_io("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
